// File: rtl/irq_latch4.sv
// irq_latch4 -- four-source interrupt latch with edge capture, mask and overflow.
//
// Each asynchronous request line is synchronized, its rising edge is detected
// against a history flop, and the edge sets a sticky pending bit. A consumer
// clears one pending bit per ack. An edge arriving on a source that is already
// pending (and not being acked that cycle) sets a sticky overflow flag.
//
// Ports
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      [3:0] asynchronous request lines, bit n = source n
//   mask_we  mask write strobe
//   mask_in  [3:0] new mask value, 1 = source enabled
//   ack      acknowledge strobe
//   ack_idx  [1:0] pending bit cleared on ack
//   ovf_clr  clears all overflow flags
//   i0..i3   masked pending lines (feed a 4-to-2 priority encoder)
//   pend     [3:0] raw pending register
//   ovf      [3:0] sticky overflow flags
//   irq      OR of i0..i3
//
// SYNC_STAGES: synchronizer depth per request line, legal range 2..4.

module irq_latch4 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       ovf_clr,
  output logic       i0,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic [3:0] pend,
  output logic [3:0] ovf,
  output logic       irq
);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  hist_q;
  logic [3:0]                  mask_q;
  logic [3:0]                  rise;
  logic [3:0]                  ack_clr;
  logic [3:0]                  pend_d;
  logic [3:0]                  ovf_d;
  logic [3:0]                  masked;

  // Stage 0 samples req; the last stage is the synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
    ack_clr = ack ? (4'b0001 << ack_idx) : 4'b0000;
    // A new edge wins over an ack of the same bit, and is not an overflow
    // because the old pending event is being consumed on this edge.
    pend_d  = (pend & ~ack_clr) | rise;
    ovf_d   = (ovf & ~{4{ovf_clr}}) | (rise & pend & ~ack_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      ovf    <= '0;
      mask_q <= 4'b1111;
    end else begin
      pend <= pend_d;
      ovf  <= ovf_d;
      if (mask_we) begin
        mask_q <= mask_in;
      end
    end
  end

  assign masked = pend & mask_q;
  assign i0     = masked[0];
  assign i1     = masked[1];
  assign i2     = masked[2];
  assign i3     = masked[3];
  assign irq    = |masked;

endmodule

// File: tb/tb_irq_latch4.sv
// Testbench for irq_latch4: directed stimulus pushes hand-computed expected
// states into a queue; a monitor process pops and compares them against the
// DUT outputs each time the stimulus signals that outputs are ready to sample.

module tb_irq_latch4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ovf_clr;
  logic       i0, i1, i2, i3;
  logic [3:0] pend;
  logic [3:0] ovf;
  logic       irq;

  irq_latch4 #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .ack     (ack),
    .ack_idx (ack_idx),
    .ovf_clr (ovf_clr),
    .i0      (i0),
    .i1      (i1),
    .i2      (i2),
    .i3      (i3),
    .pend    (pend),
    .ovf     (ovf),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [3:0] i;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare every queued expectation when the stimulus says "sample".
  initial begin
    exp_t       e;
    logic [3:0] i_act;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        i_act = {i3, i2, i1, i0};
        checks++;
        if (pend !== e.pend || ovf !== e.ovf || i_act !== e.i || irq !== e.irq) begin
          errors++;
          $display("FAIL %s: got pend=%b ovf=%b i=%b irq=%b, expected pend=%b ovf=%b i=%b irq=%b",
                   e.name, pend, ovf, i_act, irq, e.pend, e.ovf, e.i, e.irq);
        end
      end
    end
  end

  task automatic expect_state(input string name, input logic [3:0] p, input logic [3:0] o,
                              input logic [3:0] i, input logic q);
    exp_t e;
    e.name = name;
    e.pend = p;
    e.ovf  = o;
    e.i    = i;
    e.irq  = q;
    exp_q.push_back(e);
    -> chk_ev;
    #0;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    mask_we = 1'b0;
    mask_in = 4'b0000;
    ack     = 1'b0;
    ack_idx = 2'd0;
    ovf_clr = 1'b0;
    #12;
    expect_state("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #8;
    rst_n = 1'b1;
    tick(2);

    // Single source edge: latency of exactly three edges.
    req = 4'b0100;
    tick(1);
    expect_state("lat_edge1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    expect_state("lat_edge2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    expect_state("lat_edge3", 4'b0100, 4'b0000, 4'b0100, 1'b1);
    tick(2);
    expect_state("level_held_once", 4'b0100, 4'b0000, 4'b0100, 1'b1);
    req = 4'b0000;
    ack = 1'b1; ack_idx = 2'd2;
    tick(1);
    ack = 1'b0;
    expect_state("ack_src2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(3);

    // Two sources pending, ack one at a time.
    req = 4'b1010;
    tick(3);
    expect_state("pend_1010", 4'b1010, 4'b0000, 4'b1010, 1'b1);
    req = 4'b0000;
    ack = 1'b1; ack_idx = 2'd3;
    tick(1);
    expect_state("ack_idx3", 4'b0010, 4'b0000, 4'b0010, 1'b1);
    ack_idx = 2'd1;
    tick(1);
    ack = 1'b0;
    expect_state("ack_idx1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(3);

    // Masked source still latches; unmasking exposes it next cycle.
    mask_we = 1'b1; mask_in = 4'b0111;
    tick(1);
    mask_we = 1'b0;
    req = 4'b1000;
    tick(3);
    expect_state("masked_src3", 4'b1000, 4'b0000, 4'b0000, 1'b0);
    req = 4'b0000;
    mask_we = 1'b1; mask_in = 4'b1111;
    tick(1);
    mask_we = 1'b0;
    expect_state("unmask_src3", 4'b1000, 4'b0000, 4'b1000, 1'b1);
    // ack and mask write on the same edge both apply.
    ack = 1'b1; ack_idx = 2'd3;
    mask_we = 1'b1; mask_in = 4'b0000;
    tick(1);
    ack = 1'b0; mask_we = 1'b0;
    expect_state("ack_with_maskwe", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    req = 4'b0001;
    tick(3);
    expect_state("mask_all_off", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    req = 4'b0000;
    mask_we = 1'b1; mask_in = 4'b1111;
    tick(1);
    mask_we = 1'b0;
    expect_state("mask_restored", 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(2);

    // Overflow on source 0 (pend[0] already set).
    req = 4'b0001;
    tick(2);
    expect_state("ovf_not_yet", 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(1);
    expect_state("ovf_src0", 4'b0001, 4'b0001, 4'b0001, 1'b1);
    req = 4'b0000;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    expect_state("ovf_clr", 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(3);
    req = 4'b0001;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    expect_state("ovf_set_beats_clr", 4'b0001, 4'b0001, 4'b0001, 1'b1);
    req = 4'b0000;
    tick(3);

    // Ack and edge on the same source, same edge: set wins, no overflow.
    req = 4'b0100;
    tick(3);
    expect_state("pend_0101", 4'b0101, 4'b0001, 4'b0101, 1'b1);
    req = 4'b0000;
    tick(3);
    req = 4'b0100;
    tick(2);
    ack = 1'b1; ack_idx = 2'd2;
    tick(1);
    expect_state("ack_vs_set_src2", 4'b0101, 4'b0001, 4'b0101, 1'b1);
    ack_idx = 2'd3;
    tick(1);
    ack = 1'b0;
    expect_state("ack_zero_bit", 4'b0101, 4'b0001, 4'b0101, 1'b1);
    req = 4'b0000;
    tick(3);

    // Async reset mid-operation, with req held high through it.
    mask_we = 1'b1; mask_in = 4'b0000;
    tick(1);
    mask_we = 1'b0;
    req = 4'b1111;
    tick(3);
    expect_state("pend_1111_masked", 4'b1111, 4'b0101, 4'b0000, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_state("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #1;
    rst_n = 1'b1;
    tick(2);
    expect_state("post_reset_edge2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    expect_state("post_reset_edge3", 4'b1111, 4'b0000, 4'b1111, 1'b1);
    tick(2);
    expect_state("post_reset_held", 4'b1111, 4'b0000, 4'b1111, 1'b1);

    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
